bsg_sipo: RTL and testbench
===========================

// Module: bsg_sipo
// PURPOSE
//  Serial-in parallel-out deserializer; the receive-side counterpart of bsg_piso.
//  Consumes a 1-bit stream, LSB first, on a valid-then-yumi channel and assembles width_p-bit words.
//  Presents each word on a valid-then-yumi parallel channel through a one-word output buffer.
//  The next frame shifts in while the previous word waits, so the block sustains 1 bit/cycle.
// PARAMETERS
//  width_p   "inv"   parallel word width in bits; must be overridden, legal range >= 2
// PORTS
//  clk_i      in   1        clock; all state updates on posedge
//  reset_n_i  in   1        reset, asynchronous, active-low
//  valid_i    in   1        serial bit valid (helpful: independent of yumi_o)
//  yumi_o     out  1        serial bit consumed this cycle (demanding: asserted only with valid_i)
//  data_i     in   1        serial bit
//  valid_o    out  1        parallel word valid; registered, independent of yumi_i
//  yumi_i     in   1        downstream consumes word; legal only while valid_o=1
//  data_o     out  width_p  parallel word; bit k = k-th bit received in the frame
//  parity_err_o out 1       only with BSG_SIPO_PARITY_EN; qualified by valid_o
// BEHAVIOUR
//  State:
//   - shift_r[width_p-1:0]: partial frame.
//   - cnt_r: bits held in the frame, 0..F-1. F = width_p, or width_p+1 with parity.
//   - out_r, out_v_r: output buffer and its valid flag.
//  Reset (reset_n_i=0, asynchronous):
//   - cnt_r=0, shift_r=0, out_r=0, out_v_r=0; parity_err_o=0.
//   - valid_o=0 and data_o=0 immediately.
//   - yumi_o=0 while reset is asserted.
//  Reset mid-frame: discard the partial frame; no word is produced from it.
//  last = (cnt_r == F-1).
//  Stall:
//   - stall = last && out_v_r && !yumi_i.
//   - yumi_o = valid_i && !stall && reset_n_i. Combinational path from yumi_i to yumi_o is intended.
//  Bit accept (yumi_o=1), not last:
//   - shift_r[cnt_r] <= data_i; cnt_r <= cnt_r+1.
//  Frame complete (yumi_o=1 && last):
//   - out_r <= assembled word, where bit width_p-1 = data_i when F = width_p.
//   - out_v_r <= 1; cnt_r <= 0.
//  Output handshake:
//   - yumi_i=1 without frame complete: out_v_r <= 0.
//   - yumi_i=1 with frame complete in the same cycle: out_v_r stays 1 and out_r takes the new word; no bubble.
//  Latency:
//   - valid_o rises on the clock edge that accepts the last frame bit, i.e. the word is visible the next cycle.
//   - Sustained throughput is 1 bit/cycle when yumi_i keeps pace.
//  Boundaries:
//   - Gaps in valid_i hold cnt_r and shift_r unchanged.
//   - Only the final bit of a frame can stall. Bits 0..F-2 of the next frame are always accepted, even while out_v_r=1.
//   - cnt_r never exceeds F-1; it wraps to 0 only on frame complete.
//   - out_r and data_o are stable while valid_o=1 and yumi_i=0.
//  Widths:
//   - cnt_r is $clog2(F) bits.
//   - Comparisons are zero-extended; no truncation is permitted.
// CONFIGURATION
//  Macro BSG_SIPO_PARITY_EN. Defined:
//   - F = width_p+1; frame bit width_p is an even-parity bit and is not stored in data_o.
//   - parity_err_o = registered (^word ^ parity_bit), loaded with out_r, held with it.
//  Undefined:
//   - F = width_p; the parity_err_o port and its logic are absent.
//   - Behaviour is otherwise identical.
// TESTING
//  Tests 1-5 run with width_p=8 and the macro undefined unless noted.
//  1. Frame 0xA5 bits LSB first, valid_i=1 continuous, yumi_i=1 when valid_o
//     -> yumi_o=1 for 8 cycles; valid_o=1 the cycle after the 8th bit, data_o=0xA5.
//  2. Frames 0x3C then 0xC3 back-to-back, yumi_i=0 for 20 cycles
//     -> 0xC3 bits 0-6 are accepted and yumi_o=0 on bit 7; data_o stays 0x3C.
//     -> On yumi_i=1: same-cycle yumi_o=1, then data_o=0xC3 next cycle with valid_o held 1.
//  3. Continuous 1-bit/cycle stream of 4 words with yumi_i=1 whenever valid_o
//     -> valid_o pulses every 8 cycles with words in order; yumi_o never drops.
//  4. Assert reset_n_i=0 asynchronously after 3 bits of a frame, release it, then send 0xFF
//     -> valid_o/data_o are 0 immediately; the next word out is 0xFF.
//  5. Frame 0x5A with valid_i randomly deasserted 50% of cycles
//     -> data_o=0x5A; no bit lost or duplicated.
//  6. BSG_SIPO_PARITY_EN: 0x01 with parity bit 1 -> parity_err_o=0; 0x01 with parity 0 -> parity_err_o=1.

Source files
------------

// File: rtl/bsg_sipo.sv
// Serial-in parallel-out deserializer, LSB first; BSG_SIPO_PARITY_EN appends an even-parity bit per frame.
// Latency: word visible the cycle after its last serial bit is accepted; sustains 1 bit/cycle.
// Backpressure: only the final frame bit stalls (buffer full and not yumi'd); earlier bits always accepted.
module bsg_sipo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               valid_i,
    output logic               yumi_o,
    input  logic               data_i,
    output logic               valid_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
`ifdef BSG_SIPO_PARITY_EN
    ,
    output logic               parity_err_o
`endif
);

`ifdef BSG_SIPO_PARITY_EN
    localparam int frame_lp = width_p + 1;
`else
    localparam int frame_lp = width_p;
`endif
    localparam int cnt_w_lp = $clog2(frame_lp);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(frame_lp - 1);

    logic [width_p-1:0]  shift_r;
    logic [width_p-1:0]  shift_in;
    logic [cnt_w_lp-1:0] cnt_r;
    logic [width_p-1:0]  out_r;
    logic                out_v_r;
    logic                last;
    logic                stall;
    logic                frame_done;

    assign last       = (cnt_r == last_cnt_lp);
    assign stall      = last && out_v_r && !yumi_i;
    assign yumi_o     = valid_i && !stall && reset_n_i;
    assign frame_done = yumi_o && last;

    // Partial frame with the incoming bit merged at its position; a parity bit
    // lands past the word and leaves the data bits untouched.
    always_comb begin
        shift_in = shift_r;
        for (int k = 0; k < width_p; k++) begin
            if (int'(cnt_r) == k) begin
                shift_in[k] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shift_r <= '0;
            cnt_r   <= '0;
        end else if (yumi_o) begin
            if (last) begin
                cnt_r <= '0;
            end else begin
                shift_r <= shift_in;
                cnt_r   <= cnt_r + cnt_w_lp'(1);
            end
        end
    end

    // A completing frame takes priority over the consume, so a same-cycle
    // yumi_i reloads the buffer without a bubble.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_r   <= '0;
            out_v_r <= 1'b0;
        end else if (frame_done) begin
            out_r   <= shift_in;
            out_v_r <= 1'b1;
        end else if (yumi_i) begin
            out_v_r <= 1'b0;
        end
    end

`ifdef BSG_SIPO_PARITY_EN
    logic parity_err_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            parity_err_r <= 1'b0;
        end else if (frame_done) begin
            parity_err_r <= (^shift_r) ^ data_i;
        end
    end

    assign parity_err_o = parity_err_r;
`endif

    assign valid_o = out_v_r;
    assign data_o  = out_r;

endmodule

// File: tb/tb_bsg_sipo.sv
// Randomized/directed bench for bsg_sipo: bit-queue driver, frame-assembling reference model, scoreboard.
module tb_bsg_sipo;

    localparam int W = 8;
`ifdef BSG_SIPO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         yumi_o;
    logic         data_i = 1'b0;
    logic         valid_o;
    logic         yumi_i = 1'b0;
    logic [W-1:0] data_o;
`ifdef BSG_SIPO_PARITY_EN
    logic         parity_err_o;
`endif

    bsg_sipo #(.width_p(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .yumi_o    (yumi_o),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .yumi_i    (yumi_i),
        .data_o    (data_o)
`ifdef BSG_SIPO_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int popped = 0;
    int stalls = 0;
    int yumi_mode = 1;   // 0: never, 1: whenever valid_o, 2: random
    int gap_pct = 0;

    bit       tx_q[$];
    bit       rx_bits[$];
    logic [W:0] exp_q[$];   // {parity_err, word}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit p);
        for (int k = 0; k < W; k++) tx_q.push_back(w[k]);
        if (F > W) tx_q.push_back(p);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_frame(w, ^w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || rx_bits.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 1);
    endtask

    // Driver: inputs change 1 time unit after the active edge.
    bit take;
    initial begin
        forever begin
            @(negedge clk_i);
            take = yumi_o;
            @(posedge clk_i);
            #1;
            if (take && tx_q.size() != 0) void'(tx_q.pop_front());
            if (tx_q.size() != 0 && $urandom_range(99) >= 32'(gap_pct)) begin
                valid_i = 1'b1;
                data_i  = tx_q[0];
            end else begin
                valid_i = 1'b0;
                data_i  = 1'($urandom);
            end
            case (yumi_mode)
                0:       yumi_i = 1'b0;
                1:       yumi_i = valid_o;
                default: yumi_i = valid_o && ($urandom_range(1) == 1);
            endcase
        end
    end

    // Monitor / reference model: sampled mid-cycle, describing the upcoming edge.
    logic [W:0]   head;
    logic [W-1:0] wd;
    bit           full;
    bit           exp_yumi;
    bit           pb;
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            check("rst_valid_o", 32'(valid_o), 0);
            check("rst_data_o", 32'(data_o), 0);
            check("rst_yumi_o", 32'(yumi_o), 0);
            rx_bits.delete();
            exp_q.delete();
        end else begin
            full = (exp_q.size() != 0);
            check("valid_o", 32'(valid_o), 32'(full));
            if (full) begin
                head = exp_q[0];
                check("data_o", 32'(data_o), 32'(head[W-1:0]));
`ifdef BSG_SIPO_PARITY_EN
                check("parity_err_o", 32'(parity_err_o), 32'(head[W]));
`endif
            end
            exp_yumi = valid_i && !(rx_bits.size() == F - 1 && full && !yumi_i);
            check("yumi_o", 32'(yumi_o), 32'(exp_yumi));
            if (valid_i && !yumi_o) stalls++;
            if (valid_o && yumi_i && full) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (yumi_o) begin
                rx_bits.push_back(data_i);
                if (rx_bits.size() == F) begin
                    wd = '0;
                    for (int k = 0; k < W; k++) wd[k] = rx_bits[k];
                    pb = 1'b0;
`ifdef BSG_SIPO_PARITY_EN
                    pb = rx_bits[W];
`endif
                    exp_q.push_back({(F > W) ? ((^wd) ^ pb) : 1'b0, wd});
                    rx_bits.delete();
                end
            end
        end
    end

    int p0;
    int s0;
    int n;
    initial begin
        repeat (3) @(posedge clk_i);
        #3 reset_n_i = 1'b1;

        // 1: single frame, consumer always ready
        yumi_mode = 1; gap_pct = 0;
        p0 = popped;
        send_word(8'hA5);
        drain();
        check("t1_words", 32'(popped - p0), 1);

        // 2: back-to-back frames while the consumer stalls
        yumi_mode = 0;
        send_word(8'h3C);
        send_word(8'hC3);
        repeat (20) @(posedge clk_i);
        #2;
        check("t2_hold_data", 32'(data_o), 32'h3C);
        check("t2_hold_valid", 32'(valid_o), 1);
        check("t2_stall_yumi", 32'(yumi_o), 0);
        check("t2_pending_bits", 32'(tx_q.size()), 1);
        yumi_mode = 1;
        @(posedge clk_i); #2;
        check("t2_release_yumi", 32'(yumi_o), 1);
        @(posedge clk_i); #2;
        check("t2_next_data", 32'(data_o), 32'hC3);
        check("t2_next_valid", 32'(valid_o), 1);
        drain();

        // 3: continuous stream, no stalls expected
        s0 = stalls; p0 = popped;
        send_word(8'h11); send_word(8'h22); send_word(8'h44); send_word(8'h88);
        drain();
        check("t3_no_stall", 32'(stalls - s0), 0);
        check("t3_words", 32'(popped - p0), 4);

        // 4: reset mid-frame with a word parked in the buffer
        yumi_mode = 0;
        send_word(8'h77);
        send_word(8'h00);
        n = 0;
        while (!(rx_bits.size() == 3 && exp_q.size() == 1) && n < 200) begin
            @(posedge clk_i); #3;
            n++;
        end
        check("t4_reach_timeout", 32'(n < 200), 1);
        check("t4_pre_data", 32'(data_o), 32'h77);
        reset_n_i = 1'b0;
        tx_q.delete();
        #1;
        check("t4_async_valid", 32'(valid_o), 0);
        check("t4_async_data", 32'(data_o), 0);
        check("t4_async_yumi", 32'(yumi_o), 0);
        repeat (2) @(posedge clk_i);
        #3 reset_n_i = 1'b1;
        yumi_mode = 1;
        p0 = popped;
        send_word(8'hFF);
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk_i); #2;
            n++;
        end
        check("t4_wait_timeout", 32'(n < 100), 1);
        check("t4_first_word", 32'(data_o), 32'hFF);
        drain();
        check("t4_words", 32'(popped - p0), 1);

        // 5: 50% gaps in valid_i
        gap_pct = 50; p0 = popped;
        send_word(8'h5A);
        drain();
        check("t5_words", 32'(popped - p0), 1);

`ifdef BSG_SIPO_PARITY_EN
        // 6: good and bad parity
        gap_pct = 0; p0 = popped;
        send_frame(8'h01, 1'b1);
        send_frame(8'h01, 1'b0);
        drain();
        check("t6_words", 32'(popped - p0), 2);
`endif

        // Random traffic with random gaps and consumer stalls
        gap_pct = 30; yumi_mode = 2; p0 = popped;
        for (int i = 0; i < 40; i++) begin
`ifdef BSG_SIPO_PARITY_EN
            send_frame(8'($urandom), 1'($urandom));
`else
            send_word(8'($urandom));
`endif
        end
        drain();
        check("rand_words", 32'(popped - p0), 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
